// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: widths, opcodes, FSM states.
package alu_pkg;

   localparam int DATA_WIDTH_DFLT = 32;
   localparam int OP_WIDTH_DFLT   = 4;

   // Opcodes understood by the current ALU; the arbiter never decodes them.
   localparam logic [3:0] ADDI = 4'b0000;
   localparam logic [3:0] SUB  = 4'b0001;
   localparam logic [3:0] SRLI = 4'b0011;
   localparam logic [3:0] LUI  = 4'b1000;
   localparam logic [3:0] ORI  = 4'b1001;
   localparam logic [3:0] SLLI = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } alu_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select with a single priority flop.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   input  logic grant_en,
   output logic winner
);

   logic prio;

   // A lone requester always wins; on contention the priority bit decides.
   always_comb begin
      winner = 1'b0;
      if (valid0 && valid1) winner = prio;
      else if (valid1)      winner = 1'b1;
   end

   // After every grant the other requester gets priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        prio <= 1'b0;
      else if (grant_en) prio <= ~winner;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one transaction at a time.
//
// Handshakes: every channel transfers on a rising edge where valid and ready
// are both high. A requester holds valid and payload stable until that edge;
// the arbiter never drops a request once ready has been seen with valid.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH_DFLT,
   parameter int OP_WIDTH   = alu_pkg::OP_WIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [OP_WIDTH-1:0]   req0_op_i,
   input  logic [DATA_WIDTH-1:0] req0_a_i,
   input  logic [DATA_WIDTH-1:0] req0_b_i,
   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [OP_WIDTH-1:0]   req1_op_i,
   input  logic [DATA_WIDTH-1:0] req1_a_i,
   input  logic [DATA_WIDTH-1:0] req1_b_i,
   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_result_o,
   output logic                  rsp_zero_o,
   output logic [OP_WIDTH-1:0]   alu_op_o,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_zero_i,
   output logic [1:0]            dbg_state_o
);

   alu_state_e            state;
   logic                  winner;
   logic                  accept;
   logic                  grant_q;
   logic [OP_WIDTH-1:0]   op_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  zero_q;
   logic                  rsp0_valid_q;
   logic                  rsp1_valid_q;
   logic                  rsp_taken;

   rr_arbiter2 u_rr (
      .clk      (clk),
      .reset    (reset),
      .valid0   (req0_valid_i),
      .valid1   (req1_valid_i),
      .grant_en (accept),
      .winner   (winner)
   );

   // Request-side handshake; ready is masked during reset so nothing looks accepted.
   always_comb begin
      req0_ready_o = reset && (state == ST_IDLE) && req0_valid_i && !winner;
      req1_ready_o = reset && (state == ST_IDLE) && req1_valid_i &&  winner;
      accept       = req0_ready_o || req1_ready_o;
      rsp_taken    = grant_q ? rsp1_ready_i : rsp0_ready_i;
   end

   // Sequencer: latch the winner's request, capture the ALU output, hold it until taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         grant_q      <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  grant_q <= winner;
                  op_q    <= winner ? req1_op_i : req0_op_i;
                  a_q     <= winner ? req1_a_i  : req0_a_i;
                  b_q     <= winner ? req1_b_i  : req0_b_i;
                  state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               result_q     <= alu_result_i;
               zero_q       <= alu_zero_i;
               rsp0_valid_q <= !grant_q;
               rsp1_valid_q <=  grant_q;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_taken) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: begin
               rsp0_valid_q <= 1'b0;
               rsp1_valid_q <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand and response registers drive the outputs directly.
   always_comb begin
      alu_op_o     = op_q;
      alu_a_o      = a_q;
      alu_b_o      = b_q;
      rsp_result_o = result_q;
      rsp_zero_o   = zero_q;
      rsp0_valid_o = rsp0_valid_q;
      rsp1_valid_o = rsp1_valid_q;
      dbg_state_o  = state;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic [3:0]  alu_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
      .req0_a_i(req0_a), .req0_b_i(req0_b),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
      .req1_a_i(req1_a), .req1_b_i(req1_b),
      .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
      .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero),
      .dbg_state_o(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; unsupported opcodes return 0.
   always_comb begin
      alu_result = 32'h0;
      case (alu_op)
         ADDI:    alu_result = alu_a + alu_b;
         SUB:     alu_result = alu_a - alu_b;
         ORI:     alu_result = alu_a | alu_b;
         LUI:     alu_result = alu_b << 12;
         SLLI:    alu_result = alu_a << alu_b[4:0];
         SRLI:    alu_result = alu_a >> alu_b[4:0];
         default: alu_result = 32'h0;
      endcase
      alu_zero = (alu_result == 32'h0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " state"},  32'(dbg_state), 32'(ST_IDLE));
      chk({tag, " alu_op"}, 32'(alu_op), 32'h0);
      chk({tag, " alu_a"},  alu_a, 32'h0);
      chk({tag, " alu_b"},  alu_b, 32'h0);
      chk({tag, " result"}, rsp_result, 32'h0);
      chk({tag, " zero"},   32'(rsp_zero), 32'h0);
      chk({tag, " rsp0_v"}, 32'(rsp0_valid), 32'h0);
      chk({tag, " rsp1_v"}, 32'(rsp1_valid), 32'h0);
      chk({tag, " req0_r"}, 32'(req0_ready), 32'h0);
      chk({tag, " req1_r"}, 32'(req1_ready), 32'h0);
   endtask

   task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      if (id == 0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // One complete transaction from a single requester, with optional response stall.
   task automatic do_op(input string tag, input int id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero, input int hold);
      drive_req(id, op, a, b);
      #1;
      chk({tag, " ready0"}, 32'(req0_ready), (id == 0) ? 32'h1 : 32'h0);
      chk({tag, " ready1"}, 32'(req1_ready), (id == 1) ? 32'h1 : 32'h0);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk({tag, " exec state"}, 32'(dbg_state), 32'(ST_EXEC));
      chk({tag, " alu_op"}, 32'(alu_op), 32'(op));
      chk({tag, " alu_a"}, alu_a, a);
      chk({tag, " alu_b"}, alu_b, b);
      chk({tag, " exec rsp_v"}, 32'({rsp1_valid, rsp0_valid}), 32'h0);
      tick;
      chk({tag, " rsp_v"}, 32'({rsp1_valid, rsp0_valid}), (id == 0) ? 32'h1 : 32'h2);
      chk({tag, " result"}, rsp_result, exp_res);
      chk({tag, " zero"}, 32'(rsp_zero), 32'(exp_zero));
      for (int k = 0; k < hold; k++) begin
         // The other requester's response ready and fresh requests must be ignored.
         if (id == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         tick;
         chk({tag, " hold rsp_v"}, 32'({rsp1_valid, rsp0_valid}), (id == 0) ? 32'h1 : 32'h2);
         chk({tag, " hold result"}, rsp_result, exp_res);
         chk({tag, " hold zero"}, 32'(rsp_zero), 32'(exp_zero));
         chk({tag, " hold ready"}, 32'({req1_ready, req0_ready}), 32'h0);
         chk({tag, " hold alu_a"}, alu_a, a);
         chk({tag, " hold alu_b"}, alu_b, b);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = (id == 0);
      rsp1_ready = (id == 1);
      tick;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      chk({tag, " done state"}, 32'(dbg_state), 32'(ST_IDLE));
      chk({tag, " done rsp_v"}, 32'({rsp1_valid, rsp0_valid}), 32'h0);
      chk({tag, " kept result"}, rsp_result, exp_res);
   endtask

   initial begin
      reset = 1'b0;
      req0_valid = 1'b0; req0_op = 4'h0; req0_a = 32'h0; req0_b = 32'h0;
      req1_valid = 1'b0; req1_op = 4'h0; req1_a = 32'h0; req1_b = 32'h0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // Reset values, with a request pending to show ready stays low.
      #2;
      req0_valid = 1'b1;
      #1;
      chk_reset_outputs("por");
      req0_valid = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;

      // Basic operations
      do_op("add", 0, ADDI, 32'd5, 32'd7, 32'd12, 1'b0, 0);
      do_op("sub", 1, SUB, 32'd9, 32'd9, 32'd0, 1'b1, 0);
      do_op("lui", 1, LUI, 32'h0, 32'h0001_2345, 32'h1234_5000, 1'b0, 0);
      do_op("srli", 0, SRLI, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 0);
      do_op("unk", 0, 4'b0111, 32'h1234, 32'h5678, 32'h0, 1'b1, 0);
      do_op("bp", 0, ADDI, 32'hFFFF_FFFF, 32'd2, 32'h1, 1'b0, 5);

      // Reset during EXEC
      drive_req(1, ADDI, 32'd3, 32'd4);
      tick;
      req1_valid = 1'b0;
      chk("rx exec state", 32'(dbg_state), 32'(ST_EXEC));
      reset = 1'b0;
      req0_valid = 1'b1;
      #1;
      chk_reset_outputs("rx");
      req0_valid = 1'b0;
      #1;
      reset = 1'b1;
      tick;
      chk("rx after state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rx after rsp_v", 32'({rsp1_valid, rsp0_valid}), 32'h0);

      // Reset during RESP
      drive_req(1, ORI, 32'h10, 32'h01);
      tick;
      req1_valid = 1'b0;
      tick;
      chk("rr resp rsp1_v", 32'(rsp1_valid), 32'h1);
      chk("rr resp result", rsp_result, 32'h11);
      reset = 1'b0;
      #1;
      chk_reset_outputs("rr");
      #1;
      reset = 1'b1;
      tick;
      chk("rr after rsp_v", 32'({rsp1_valid, rsp0_valid}), 32'h0);

      // Contention: both always valid, grants must alternate starting with req0.
      for (int i = 0; i < 10; i++) begin
         drive_req(0, ORI, 32'hF0, 32'h0F ^ 32'(i));
         drive_req(1, SLLI, 32'h1, 32'd4 + 32'(i));
         for (int g = 0; g < 2; g++) begin
            #1;
            chk("ct ready0", 32'(req0_ready), (g == 0) ? 32'h1 : 32'h0);
            chk("ct ready1", 32'(req1_ready), (g == 1) ? 32'h1 : 32'h0);
            tick;
            chk("ct exec ready", 32'({req1_ready, req0_ready}), 32'h0);
            chk("ct alu_op", 32'(alu_op), (g == 0) ? 32'(ORI) : 32'(SLLI));
            tick;
            chk("ct rsp_v", 32'({rsp1_valid, rsp0_valid}), (g == 0) ? 32'h1 : 32'h2);
            chk("ct result", rsp_result,
                (g == 0) ? (32'hF0 | (32'h0F ^ 32'(i))) : (32'h1 << (4 + i)));
            rsp0_ready = (g == 0);
            rsp1_ready = (g == 1);
            tick;
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
            chk("ct idle", 32'(dbg_state), 32'(ST_IDLE));
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit combinational ALU between two requesters, for example the EX stage and a CSR/debug unit. Each requester gets a valid/ready request channel and a valid/ready response channel. The arbiter grants round-robin, registers operands and opcode into the ALU, captures result and zero flag, and holds the response until the winner accepts it. One transaction is in flight at a time.

## Interface
- DATA_WIDTH, 32, operand/result width
- OP_WIDTH, 4, ALU opcode width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid_i / req1_valid_i  in  1  request present
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid also high
- req0_op_i / req1_op_i  in  OP_WIDTH  ALU opcode
- req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  DATA_WIDTH  operands
- rsp0_valid_o / rsp1_valid_o  out  1  result available for that requester
- rsp0_ready_i / rsp1_ready_i  in  1  requester takes result
- rsp_result_o  out  DATA_WIDTH  shared result bus, meaningful only while some rspN_valid_o is high
- rsp_zero_o  out  1  zero flag accompanying rsp_result_o
- alu_op_o  out  OP_WIDTH  opcode to ALU
- alu_a_o, alu_b_o  out  DATA_WIDTH  operands to ALU
- alu_result_i  in  DATA_WIDTH  ALU result
- alu_zero_i  in  1  ALU zero flag

## Operation
- FSM with three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Winner selection: if only one valid is high, that requester wins. If both are high, the requester with priority wins: prio=0 means req0, prio=1 means req1.
  - reqN_ready_o = (state==IDLE) && winner==N. Ready may depend on valid. Ready is never high for both requesters.
  - On handshake: latch op, a and b into the operand registers. Record the grant ID. Set prio to the opposite of the grant ID. Go to EXEC.
- **EXEC**
  - ALU is driven from the operand registers.
  - Capture alu_result_i and alu_zero_i into the response registers. Go to RESP.
- **RESP**
  - rsp{grant}_valid_o=1; the other response valid stays 0.
  - When rsp{grant}_ready_i=1: go to IDLE. The response registers are left unchanged.
  - Both req ready outputs are 0.
- Opcode-agnostic: the opcode is passed through unchecked. Unsupported opcodes return whatever the ALU returns (0 for the current ALU).
- Requests that are not granted must be held by the requester (valid stays high, payload stable). The arbiter does not drop or reorder them.

## Timing
- Reset (async assert, synchronous-release friendly) forces:
  - state=IDLE, prio=0 (req0 first)
  - alu_op_o=0, alu_a_o=0, alu_b_o=0
  - rsp_result_o=0, rsp_zero_o=0
  - rspN_valid_o=0, reqN_ready_o=0 while reset is low
- Accept at edge E0. EXEC occupies the cycle after E0. Result is captured at E1, so rspN_valid_o is high from E1 onward: 2 cycles from accept to valid.
- rsp_valid stays high until an edge Ek samples ready=1. State is IDLE after Ek. The earliest next accept is Ek+1.
- Peak throughput: one operation per 3 cycles.
- alu_*_o change only at the accept edge and are stable through EXEC and RESP.
- Simultaneous requests: both valid at every IDLE cycle gives strictly alternating grants.
- Reset asserted mid-EXEC or mid-RESP: the transaction is discarded, no response is issued, and the operands are cleared.
- Response ready asserted outside RESP, or by the non-granted requester, is ignored.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: LUI=4'b1000, ORI=4'b1001, ADDI=4'b0000, SLLI=4'b1100, SRLI=4'b0011, SUB=4'b0001
  - the FSM state encoding
  - the DATA_WIDTH/OP_WIDTH defaults
- One sub-module: rr_arbiter2.
  - Combinational winner select from the two valids and prio, plus the prio flop updated on grant.
- FSM and data registers live in alu_arbiter.

## Test plan
- **Single add:** req0 ADDI a=5 b=7 -> rsp0_valid 2 cycles after accept, result=12, zero=0. rsp1_valid stays 0.
- **Zero flag:** req1 SUB a=9 b=9 -> rsp1 result=0, zero=1. LUI b=0x00012345 -> result=0x12345000.
- **Contention:** req0 ORI 0xF0|0x0F and req1 SLLI 1<<4 both valid after reset -> req0 is granted first (0xFF), then req1 (16). Ten back-to-back pairs alternate grants exactly.
- **Backpressure:** rsp0_ready held low 5 cycles -> rsp0_valid, result and zero remain stable. Both req ready stay 0 and ALU inputs are unchanged. Ready high -> IDLE next cycle.
- **Reset mid-op:** assert reset during EXEC, then during RESP -> all outputs reach reset values immediately, no response is issued, and the first post-reset request gets req0 priority.
- **Unknown opcode:** 4'b0111 -> result=0, zero=1, and the handshake completes normally.
